// File: rtl/fp_norm_round.sv
// fp_norm_round: iterative normalize, round-to-nearest-even and binary32 pack stage
// with flush-to-zero and an [EXACT, OVERFLOW, UNDERFLOW, INEXACT] status word.
module fp_norm_round #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       data_out,
  output logic [3:0]        status_out
);
  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;
  localparam logic signed [EXP_W:0] ONE  = 1;
  localparam logic signed [EXP_W:0] EMAX = 255;
  localparam logic signed [EXP_W:0] EMIN = 0;
  state_t                  state_q, state_d;
  logic                    sign_q, sign_d, inx_q, inx_d;
  logic signed [EXP_W:0]   exp_q, exp_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic [31:0]             data_q, data_d;
  logic [3:0]              status_q, status_d;
  logic                    up, zero, ovf, unf;
  logic [MANT_W-4:0]       sum;
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign data_out   = data_q;
  assign status_out = status_q;
  assign up   = mant_q[2] & (mant_q[3] | mant_q[1] | mant_q[0]);
  assign sum  = mant_q[MANT_W-1:3] + {{(MANT_W-4){1'b0}}, up};
  assign zero = mant_q == '0;
  assign ovf  = exp_q >= EMAX;
  assign unf  = exp_q <= EMIN;
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    inx_d    = inx_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = NORM;
        sign_d  = in_sign;
        exp_d   = {in_exp[EXP_W-1], in_exp};
        mant_d  = in_mant;
        inx_d   = 1'b0;
      end
      NORM: if (zero) state_d = PACK;
        else if (mant_q[MANT_W-1]) begin
          // right shift keeps the discarded bits alive in the sticky position
          mant_d = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + ONE;
        end else if (!mant_q[MANT_W-2]) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - ONE;
        end else state_d = ROUND;
      ROUND: begin
        mant_d  = {sum, 3'b000};
        inx_d   = inx_q | (|mant_q[2:0]);
        state_d = sum[MANT_W-4] ? NORM : PACK;
      end
      PACK: begin
        state_d  = DONE;
        data_d   = zero ? {sign_q, 31'b0} : ovf ? {sign_q, 8'hFF, 23'b0} :
                   unf ? {sign_q, 31'b0} : {sign_q, exp_q[7:0], mant_q[25:3]};
        status_d = zero ? 4'b1000 : ovf ? 4'b0101 : unf ? 4'b0011 : inx_q ? 4'b0001 : 4'b1000;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      inx_q    <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      inx_q    <= inx_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed vectors with hand-computed binary32 results for fp_norm_round.
module tb_fp_norm_round;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic        in_sign = 0;
  logic [9:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  int vectors = 0;
  int miscompares = 0;
  int lat;

  fp_norm_round dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one operand at a negedge, then count edges until out_valid (bounded)
  task automatic launch(input logic s, input logic [9:0] e, input logic [27:0] m);
    @(negedge clk);
    in_valid = 1; in_sign = s; in_exp = e; in_mant = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [9:0] e, input logic [27:0] m,
                     input logic [31:0] d, input logic [3:0] st, input int exp_lat);
    launch(s, e, m);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, data_out, d);
    check({tag, "_status"}, 32'(status_out), 32'(st));
    if (exp_lat != 0) check({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", data_out, 32'h0);
    check("rst_status", 32'(status_out), 32'h0);
    @(negedge clk);
    rst_n = 1;

    run("one",      0, 10'd127, 28'h4000000, 32'h3F800000, 4'b1000, 3);
    run("carry_in", 0, 10'd127, 28'h8000000, 32'h40000000, 4'b1000, 4);
    run("rnd_up",   0, 10'd127, 28'h400000C, 32'h3F800002, 4'b0001, 3);
    run("tie_even", 0, 10'd127, 28'h4000004, 32'h3F800000, 4'b0001, 3);
    run("rnd_cry",  1, 10'd127, 28'h7FFFFFC, 32'hC0000000, 4'b0001, 0);
    run("ovf",      0, 10'd254, 28'h8000000, 32'h7F800000, 4'b0101, 0);
    run("unf",      0, 10'd1,   28'h2000000, 32'h00000000, 4'b0011, 0);
    run("zero",     1, 10'd127, 28'h0000000, 32'h80000000, 4'b1000, 0);
    run("lshift",   0, 10'd130, 28'h1000000, 32'h40000000, 4'b1000, 5);

    out_ready = 0;
    launch(0, 10'd128, 28'h6000000);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data", data_out, 32'h40400000);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_sign = 1; in_exp = 10'd200; in_mant = 28'h5555555;
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", data_out, 32'h40400000);
      check("bp_hold_status", 32'(status_out), 32'h8);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("bp_ignored_valid", 32'(out_valid), 32'd0);
    check("bp_ignored_data", data_out, 32'h40400000);

    @(negedge clk);
    in_valid = 1; in_sign = 0; in_exp = 10'd150; in_mant = 28'h0000008;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", data_out, 32'h0);
    check("arst_status", 32'(status_out), 32'h0);
    check("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    check("arst_no_output", 32'(out_valid), 32'd0);
    run("post_rst", 0, 10'd127, 28'h4000000, 32'h3F800000, 4'b1000, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
